// File: rtl/parity_frame_engine.sv
// -----------------------------------------------------------------------------
// parity_frame_engine
//
// Registered parity generator/checker. Each DATA_W-bit word is reduced to one
// parity bit. The result covers either a single word or a whole multi-beat
// frame. In check mode the result is compared against an expected bit, and
// mismatches are counted in a saturating counter.
//
// Parameters:
//   DATA_W  input word width (>= 2)
//   CNT_W   error counter width (>= 1)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   beat qualifier
//   in_data    data word
//   in_last    last beat of a frame (frame modes only)
//   mode       00 word-generate, 01 frame-generate, 10 frame-check, 11 = 00
//   odd_sel    0 even parity, 1 odd parity
//   exp_par    expected parity, used on the closing beat of a check frame
//   clr_cnt    synchronous clear of err_cnt; wins over an increment
//   out_valid  one-cycle strobe qualifying out_par / out_err
//   out_par    computed parity (holds while out_valid is low)
//   out_err    check-mode mismatch flag (holds while out_valid is low)
//   err_cnt    saturating mismatch count
//   busy       a multi-beat frame is in progress
//
// Optional build macro:
//   PARITY_PIPE_EN  Splits the word reduction into two register stages
//                   (lower/upper half of in_data). Latency becomes 2 cycles.
//                   Throughput and busy timing are unchanged. err_cnt follows
//                   the delayed strobe.
// -----------------------------------------------------------------------------
module parity_frame_engine #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [1:0]        mode,
  input  logic              odd_sel,
  input  logic              exp_par,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam int                LO_W     = DATA_W / 2;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t state, state_nxt;
  logic   frm_odd, frm_chk;
  logic   frame_mode;

  // Modes 01 and 10 are the frame modes. Modes 00 and 11 both act as word mode.
  assign frame_mode = mode[0] ^ mode[1];

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && frame_mode && !in_last) state_nxt = ACCUM;
      ACCUM:   if (in_valid && in_last)                state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACCUM);
  end

  // Frame attributes are frozen on the first beat. The mode and odd_sel inputs
  // are ignored for the remainder of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_odd <= 1'b0;
      frm_chk <= 1'b0;
    end else if (state == IDLE && in_valid && frame_mode && !in_last) begin
      frm_odd <= odd_sel;
      frm_chk <= (mode == 2'b10);
    end
  end

  // ---------------------------------------------------------------------------
  // Beat decode: what this beat means for the accumulator/result stage
  // ---------------------------------------------------------------------------
  logic b_start, b_done, b_odd, b_chk, b_lo, b_hi;

  always_comb begin
    b_start = (state == IDLE);  // beat opens a fresh result (acc restarts)
    b_done  = 1'b0;
    b_odd   = odd_sel;
    b_chk   = (mode == 2'b10);
    if (state == ACCUM) begin
      b_done = in_valid && in_last;
      b_odd  = frm_odd;
      b_chk  = frm_chk;
    end else begin
      b_done = in_valid && (!frame_mode || in_last);
    end
  end

  assign b_lo = ^in_data[LO_W-1:0];
  assign b_hi = ^in_data[DATA_W-1:LO_W];

  // Signals seen by the result stage, either registered once or taken direct.
  logic s_valid, s_start, s_done, s_odd, s_chk, s_exp, s_lo, s_hi;

`ifdef PARITY_PIPE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_start <= 1'b0;
      s_done  <= 1'b0;
      s_odd   <= 1'b0;
      s_chk   <= 1'b0;
      s_exp   <= 1'b0;
      s_lo    <= 1'b0;
      s_hi    <= 1'b0;
    end else begin
      s_valid <= in_valid;
      s_start <= b_start;
      s_done  <= b_done;
      s_odd   <= b_odd;
      s_chk   <= b_chk;
      s_exp   <= exp_par;
      s_lo    <= b_lo;
      s_hi    <= b_hi;
    end
  end
`else
  assign s_valid = in_valid;
  assign s_start = b_start;
  assign s_done  = b_done;
  assign s_odd   = b_odd;
  assign s_chk   = b_chk;
  assign s_exp   = exp_par;
  assign s_lo    = b_lo;
  assign s_hi    = b_hi;
`endif

  // ---------------------------------------------------------------------------
  // Accumulator and registered result
  // ---------------------------------------------------------------------------
  logic acc, res, par_nxt, err_nxt;

  assign res     = (s_start ? 1'b0 : acc) ^ s_lo ^ s_hi;
  assign par_nxt = res ^ s_odd;
  assign err_nxt = s_chk && (par_nxt != s_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= 1'b0;
      out_valid <= 1'b0;
      out_par   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= s_valid && s_done;
      if (s_valid) acc <= res;
      if (s_valid && s_done) begin
        out_par <= par_nxt;
        out_err <= err_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (s_valid && s_done && err_nxt && err_cnt != CNT_MAX)
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule
